cpu_server_arbiter: RTL and testbench
=====================================

CPU_SERVER_ARBITER -- requirements
Module: cpu_server_arbiter

Interface
REQ-001 SHALL have parameter N_CPU, default 4, number of requester streams (range 2..16).
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats accepted per grant (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_vld  input  N_CPU  per-requester data valid.
REQ-006 SHALL have port in_rdy  output  N_CPU  per-requester ready (combinational).
REQ-007 SHALL have port in_data  input  64*N_CPU  requester i payload in bits [64*i+63:64*i].
REQ-008 SHALL have port out_vld  output  1  registered output valid.
REQ-009 SHALL have port out_rdy  input  1  downstream ready.
REQ-010 SHALL have port out_data  output  64  registered output payload.
REQ-011 SHALL have port out_idx  output  $clog2(N_CPU)  requester index of out_data.
REQ-012 SHALL have port beat_count  output  32  total beats delivered downstream.

Function
REQ-013 SHALL implement FSM states IDLE and XFER, plus registers cur (granted index), ptr (round-robin start), burst_cnt (8 bit).
REQ-014 In IDLE, in_rdy SHALL be all zero.
REQ-015 In IDLE with any in_vld set, SHALL select first index i with in_vld[i]=1 searching ptr, ptr+1, ... wrapping modulo N_CPU, load cur=i, burst_cnt=0, go to XFER next cycle.
REQ-016 In IDLE with in_vld all zero, SHALL remain in IDLE.
REQ-017 slot_free SHALL equal (!out_vld || out_rdy).
REQ-018 In XFER, in_rdy[cur] SHALL equal slot_free; all other in_rdy bits zero.
REQ-019 Accept SHALL occur when state=XFER and in_vld[cur] and in_rdy[cur]; next cycle out_vld=1, out_data=accepted payload, out_idx=cur (latency exactly 1 cycle).
REQ-020 When out_vld && out_rdy and no accept in the same cycle, out_vld SHALL clear next cycle; out_data/out_idx hold.
REQ-021 While out_vld && !out_rdy, out_vld, out_data and out_idx SHALL remain stable.
REQ-022 Each accept SHALL increment burst_cnt.
REQ-023 XFER SHALL return to IDLE with ptr=(cur+1) mod N_CPU when an accept makes burst_cnt reach MAX_BURST, or when slot_free and !in_vld[cur].
REQ-024 XFER SHALL NOT release on in_vld[cur] low while slot_free=0 (output stalled).
REQ-025 beat_count SHALL increment by 1 on every cycle with out_vld && out_rdy; wraps 0xFFFFFFFF -> 0.
REQ-026 Simultaneous accept and downstream pop SHALL keep out_vld=1 with the new payload; no beat lost or duplicated.
REQ-027 Steady state SHALL sustain one beat per cycle within a burst; each grant costs one IDLE arbitration cycle.
REQ-028 ptr wrap: cur=N_CPU-1 release SHALL set ptr=0.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, ptr=0, cur=0, burst_cnt=0, out_vld=0, out_data=0, out_idx=0, beat_count=0, in_rdy=0.
REQ-030 Reset asserted mid-XFER SHALL discard the in-flight output beat; after release arbitration restarts at index 0.
REQ-031 First grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-032 Reset: hold rst_n=0 with in_vld=4'b1111 -> out_vld=0, in_rdy=0, beat_count=0; release -> IDLE cycle, then cur=0 granted.
REQ-033 Single source: in_vld=4'b0100 steady, out_rdy=1, MAX_BURST=4 -> 4 beats out_idx=2 on consecutive cycles, one idle cycle, repeat; beat_count=8 after two bursts.
REQ-034 Fairness: in_vld=4'b1111 steady, out_rdy=1, MAX_BURST=2 -> out_idx sequence 0,0,1,1,2,2,3,3,0,0 with one bubble between pairs.
REQ-035 Backpressure: out_rdy=0 for 5 cycles mid-burst from source 1 with in_vld[1] dropping -> out_data stable, in_rdy[1]=0, grant retained until out_rdy=1, then release to IDLE.
REQ-036 Wrap: ptr=3, in_vld=4'b1001 -> grant index 3, then index 0, ptr=1 after release.
REQ-037 Reset mid-operation: rst_n pulse low while out_vld=1, out_idx=2 -> out_vld=0 asynchronously, beat_count=0, next grant starts search at index 0.

Source files
------------

// File: rtl/cpu_server_arbiter.sv
// rtl/cpu_server_arbiter.sv - round-robin burst arbiter merging N_CPU 64-bit request streams onto one registered output
module cpu_server_arbiter #(
    parameter int N_CPU     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CPU-1:0]         in_vld,
    output logic [N_CPU-1:0]         in_rdy,
    input  logic [64*N_CPU-1:0]      in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [63:0]              out_data,
    output logic [$clog2(N_CPU)-1:0] out_idx,
    output logic [31:0]              beat_count
);

    localparam int                IDX_W     = $clog2(N_CPU);
    localparam int                SUM_W     = IDX_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CPU - 1);
    localparam logic [SUM_W-1:0]  N_SUM     = SUM_W'(N_CPU);
    localparam logic [7:0]        BURST_LIM = 8'(MAX_BURST);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       burst_cnt;

    logic             slot_free;
    logic             accept;
    logic             last_beat;
    logic [IDX_W-1:0] cur_next;
    logic [63:0]      cur_data;
    logic [63:0]      lane [N_CPU];

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [SUM_W-1:0] cand_sum;
    logic [IDX_W-1:0] cand;

    for (genvar g = 0; g < N_CPU; g++) begin : g_lane
        assign lane[g] = in_data[64*g +: 64];
    end

    assign cur_data  = lane[cur];
    assign slot_free = !out_vld || out_rdy;
    assign accept    = (state == XFER) && in_vld[cur] && slot_free;
    assign last_beat = (burst_cnt + 8'd1) == BURST_LIM;
    assign cur_next  = (cur == LAST_IDX) ? '0 : cur + 1'b1;

    always_comb begin
        in_rdy = '0;
        if (state == XFER) begin
            in_rdy[cur] = slot_free;
        end
    end

    // First requester at or after ptr, wrapping modulo N_CPU.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < N_CPU; k++) begin
            cand_sum = {1'b0, ptr} + SUM_W'(k);
            if (cand_sum >= N_SUM) begin
                cand_sum = cand_sum - N_SUM;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!grant_found && in_vld[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= '0;
            ptr        <= '0;
            burst_cnt  <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            beat_count <= '0;
        end else begin
            if (out_vld && out_rdy) begin
                beat_count <= beat_count + 32'd1;
            end

            // An accept refills the slot in the same cycle it is popped.
            if (accept) begin
                out_vld  <= 1'b1;
                out_data <= cur_data;
                out_idx  <= cur;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cur       <= grant_idx;
                        burst_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (last_beat) begin
                            state <= IDLE;
                            ptr   <= cur_next;
                        end
                    end else if (slot_free && !in_vld[cur]) begin
                        // Only give up the grant once the output is not stalled.
                        state <= IDLE;
                        ptr   <= cur_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_server_arbiter.sv
// tb/tb_cpu_server_arbiter.sv - directed checks of cpu_server_arbiter (MAX_BURST 4 and 2 instances)
module tb_cpu_server_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_vld;
    logic         out_rdy;
    logic [255:0] in_data;

    logic [3:0]   in_rdy;
    logic         out_vld;
    logic [63:0]  out_data;
    logic [1:0]   out_idx;
    logic [31:0]  beat_count;

    logic [3:0]   in_rdy2;
    logic         out_vld2;
    logic [63:0]  out_data2;
    logic [1:0]   out_idx2;
    logic [31:0]  beat_count2;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_ss [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_fv [15] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int exp_fi [15] = '{0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 3, 3, 0, 0, 0};

    cpu_server_arbiter #(.N_CPU(4), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .beat_count (beat_count)
    );

    cpu_server_arbiter #(.N_CPU(4), .MAX_BURST(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy2),
        .in_data    (in_data),
        .out_vld    (out_vld2),
        .out_rdy    (out_rdy),
        .out_data   (out_data2),
        .out_idx    (out_idx2),
        .beat_count (beat_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dval(input int i);
        return 64'hD000_0000_0000_0000 + 64'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 4'b1111;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) in_data[64*i +: 64] = dval(i);

        // Reset held with all requesters active
        tick();
        tick();
        check("rst_out_vld", out_vld, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);

        rst_n = 1'b1;
        #1;
        check("idle_in_rdy", in_rdy, 0);
        tick();
        check("first_grant_0", in_rdy, 4'b0001);

        // Dropping valid with a free slot releases, ptr -> 1
        in_vld = 4'b0000;
        tick();
        check("drop_release_in_rdy", in_rdy, 0);
        check("drop_no_beat", out_vld, 0);

        // Single source 2: two bursts of 4 with one bubble
        in_vld = 4'b0100;
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("ss_vld_%0d", k), out_vld, 64'(exp_ss[k]));
            if (exp_ss[k] == 1) begin
                check($sformatf("ss_idx_%0d", k), out_idx, 2);
                check($sformatf("ss_data_%0d", k), out_data, dval(2));
            end
        end
        check("ss_beat_count", beat_count, 8);

        // Release leaves ptr = 3; wrap 3 -> 0
        in_vld = 4'b0000;
        tick();
        check("ss_release", in_rdy, 0);
        in_vld = 4'b1001;
        tick();
        check("wrap_grant_3", in_rdy, 4'b1000);
        tick();
        check("wrap_vld_3", out_vld, 1);
        check("wrap_idx_3", out_idx, 3);
        check("wrap_data_3", out_data, dval(3));
        in_vld = 4'b0001;
        tick();
        check("wrap_pop", out_vld, 0);
        tick();
        check("wrap_grant_0", in_rdy, 4'b0001);
        tick();
        check("wrap_vld_0", out_vld, 1);
        check("wrap_idx_0", out_idx, 0);
        in_vld = 4'b0000;
        tick();
        check("wrap_beat_count", beat_count, 10);
        in_vld = 4'b1111;
        tick();
        check("ptr_after_wrap", in_rdy, 4'b0010);

        // Backpressure mid-burst on source 1 with in_vld[1] dropping
        in_vld = 4'b0010;
        tick();
        tick();
        check("bp_vld", out_vld, 1);
        check("bp_idx", out_idx, 1);
        check("bp_beats_before", beat_count, 11);
        out_rdy = 1'b0;
        in_vld  = 4'b0000;
        in_data[64 +: 64] = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        check("bp_in_rdy_low", in_rdy, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold_vld_%0d", k), out_vld, 1);
            check($sformatf("bp_hold_data_%0d", k), out_data, dval(1));
            check($sformatf("bp_hold_idx_%0d", k), out_idx, 1);
            check($sformatf("bp_hold_rdy_%0d", k), in_rdy, 0);
        end
        check("bp_beats_held", beat_count, 11);
        out_rdy = 1'b1;
        #1;
        check("bp_grant_retained", in_rdy, 4'b0010);
        tick();
        check("bp_release_vld", out_vld, 0);
        check("bp_release_rdy", in_rdy, 0);
        check("bp_beat_count", beat_count, 12);

        // Asynchronous reset while source 2 beat is in flight
        in_vld = 4'b0100;
        tick();
        tick();
        check("mr_vld", out_vld, 1);
        check("mr_idx", out_idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_vld", out_vld, 0);
        check("mr_async_beats", beat_count, 0);
        check("mr_async_idx", out_idx, 0);
        check("mr_async_rdy", in_rdy, 0);
        in_vld = 4'b1111;
        tick();
        rst_n = 1'b1;

        // Fairness on MAX_BURST=2 instance; MAX_BURST=4 instance restarts at 0
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 0) check("mr_restart_grant_0", in_rdy, 4'b0001);
            check($sformatf("fair_vld_%0d", k), out_vld2, 64'(exp_fv[k]));
            if (exp_fv[k] == 1) begin
                check($sformatf("fair_idx_%0d", k), out_idx2, 64'(exp_fi[k]));
            end
        end
        check("fair_beat_count", beat_count2, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
